echo_ctrl: RTL and testbench
============================

# echo_ctrl

Control-and-sequencing block for the echo datapath. A host reaches it through a small register bus. It drives the datapath's `enable_in`, `delay_in` and `decay_in` inputs, and it sequences every configuration change so that no click or garbage reaches the audio output. Decay changes are ramped one step per audio sample tick. A delay change runs a full sequence: ramp decay to zero, disable the datapath so its delay-line state is discarded, load the new delay, re-enable, then ramp decay back up. The block sits between the host-side register interface and the echo datapath, and takes the datapath's `tick_out` as its sample strobe.

## Interface

Parameters:
- `DELAY_MAX_LENGTH`, default 48000: delay line depth. Written delays are clamped to `DELAY_MAX_LENGTH-1`.
- `DECAY_STEP`, default 64: decay change per tick while ramping (Q1.15 units).
- `FLUSH_CYCLES`, default 4: clk cycles `enable_out` is held low during a flush, minimum 1.

Ports:
- `clk`, in, 1: clock.
- `srst`, in, 1: synchronous reset, active-high.
- `wr_en`, in, 1: bus write strobe, single-cycle.
- `rd_en`, in, 1: bus read strobe, single-cycle.
- `addr`, in, 2: register address.
- `wdata`, in, 16: write data.
- `rdata`, out, 16: read data, valid while `ack`=1, otherwise 0.
- `ack`, out, 1: one-cycle acknowledge for every accepted strobe.
- `tick_in`, in, 1: sample strobe from the datapath's `tick_out`.
- `enable_out`, out, 1: to datapath `enable_in`.
- `delay_out`, out, 16: to datapath `delay_in`.
- `decay_out`, out, 16: to datapath `decay_in`, always ≤ 0x7FFF.
- `busy_out`, out, 1: a sequence or ramp is in progress.

## Operation

Register map:
- 0, CTRL, RW: bit0 = `en_req`. Other bits read 0.
- 1, DELAY, RW: `delay_tgt`. Write value v is stored as min(v, `DELAY_MAX_LENGTH-1`).
- 2, DECAY, RW: `decay_tgt`. Write value v is stored as min(v, 0x7FFF).
- 3, STATUS, RO: bit0 = `busy_out`; bits 2:1 = state (OFF=0, RUN=1, RAMP_DOWN=2, FLUSH=3). Writes are acked and ignored.

Bus rules:
- `wr_en` and `rd_en` high together: the write is performed, a single ack is returned, and `rdata`=0.
- Back-to-back strobes are legal every cycle.

State machine. Each state lists its outputs, then transitions in priority order:
- **OFF**: `enable_out`=0, `decay_out`=0.
  - `en_req`=1 → load `delay_out`←`delay_tgt`, set `enable_out`←1, go to RUN.
- **RUN**: `enable_out`=1.
  - On each tick, `decay_out` moves toward `decay_tgt` by min(`DECAY_STEP`, |difference|), up or down.
  - `en_req`=0 or `delay_tgt`≠`delay_out` → RAMP_DOWN. This check has priority over the ramp step in the same cycle.
- **RAMP_DOWN**: `enable_out`=1.
  - On each tick, `decay_out` -= min(`DECAY_STEP`, `decay_out`).
  - When `decay_out`=0, the next cycle sets `enable_out`←0, loads the flush counter with `FLUSH_CYCLES`, and goes to FLUSH.
  - Target changes during RAMP_DOWN do not abort the ramp.
- **FLUSH**: `enable_out`=0.
  - The counter decrements every clk (not every tick).
  - At count 0: if `en_req`=1, load `delay_out`←`delay_tgt`, set `enable_out`←1, go to RUN (the decay ramp up happens in RUN). Otherwise go to OFF.
  - `delay_out` is only ever changed while `enable_out`=0 or on the OFF/FLUSH→RUN edge.

`busy_out`: 1 in RAMP_DOWN or FLUSH, and in RUN while `decay_out`≠`decay_tgt`.

## Timing

- Reset values:
  - State OFF.
  - `enable_out`=0, `delay_out`=0, `decay_out`=0, `busy_out`=0.
  - `ack`=0, `rdata`=0.
  - `en_req`=0, `delay_tgt`=0, `decay_tgt`=0.
  - Flush counter 0.
- Bus timing:
  - A strobe sampled at edge N updates the target register at edge N.
  - `ack` and `rdata` are high/valid for the cycle after edge N.
  - A read returns the value as of edge N, so a write followed by a read on the next cycle returns the new value.
- The FSM acts on a target change from edge N+1 onwards.
- Ramp steps are applied on the edge where `tick_in`=1. Without ticks, `decay_out` holds.
- RAMP_DOWN→FLUSH takes exactly 1 cycle after `decay_out` reaches 0.
- `enable_out` low time in FLUSH is exactly `FLUSH_CYCLES` clk.
- If `decay_out`=0 on entry to RAMP_DOWN, FLUSH is entered on the next cycle with no tick required.
- `srst` mid-sequence forces all reset values at that edge. Pending targets are lost.

## Test plan

1. **Reset and bus**: reset; write DELAY=1000, DECAY=0x4000; read back each → ack exactly 1 cycle after each strobe; readback 1000 / 0x4000; all outputs still 0 and state OFF.
2. **Clamping and status**:
   - Write DELAY=0xFFFF → read back `DELAY_MAX_LENGTH-1`.
   - Write DECAY=0x9000 → read back 0x7FFF.
   - Write STATUS=0xFFFF → ack returned; STATUS reads state OFF (bits 2:1 = 0) and `busy_out`=0 (bit0 = 0).
   - Assert `wr_en` and `rd_en` together → exactly one ack, `rdata`=0.
3. **Enable ramp**: set `decay_tgt`=256, DECAY_STEP=64, write CTRL=1, drive ticks → `enable_out`=1 next cycle; `decay_out` 64,128,192,256 on successive ticks; `busy_out` drops with the 4th tick.
4. **Delay change sequence**: from RUN with `decay_out`=256, write DELAY=500 → `decay_out` steps down 192,128,64,0 on ticks; `enable_out` low for exactly 4 clk; `delay_out`=500 when `enable_out` rises; decay then ramps back to 256.
5. **Disable during ramp and reset mid-flush**:
   - Write CTRL=0 mid-ramp-up → RAMP_DOWN, then FLUSH, then OFF, with `enable_out`=0 and `decay_out`=0.
   - Assert `srst` during FLUSH → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/echo_ctrl.sv
// Control and sequencing for the echo datapath: host register bus, click-free
// decay ramping and the ramp-down / flush / reload sequence for delay changes.
module echo_ctrl #(
    parameter int unsigned DELAY_MAX_LENGTH = 48000,
    parameter int unsigned DECAY_STEP       = 64,
    parameter int unsigned FLUSH_CYCLES     = 4
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [1:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    input  logic        tick_in,
    output logic        enable_out,
    output logic [15:0] delay_out,
    output logic [15:0] decay_out,
    output logic        busy_out
);

    localparam logic [15:0] DELAY_LIMIT = 16'(DELAY_MAX_LENGTH - 1);
    localparam logic [15:0] DECAY_LIMIT = 16'h7FFF;
    localparam logic [15:0] STEP        = 16'(DECAY_STEP);
    localparam logic [15:0] FLUSH_INIT  = 16'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RUN       = 2'd1,
        ST_RAMP_DOWN = 2'd2,
        ST_FLUSH     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        en_req_q, en_req_d;
    logic [15:0] delay_tgt_q, delay_tgt_d;
    logic [15:0] decay_tgt_q, decay_tgt_d;
    logic        enable_q, enable_d;
    logic [15:0] delay_q, delay_d;
    logic [15:0] decay_q, decay_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        ack_q, ack_d;
    logic [15:0] rdata_q, rdata_d;
    logic        busy;
    logic [15:0] up_diff, dn_diff;

    always_comb begin
        busy = (state_q == ST_RAMP_DOWN) || (state_q == ST_FLUSH) ||
               ((state_q == ST_RUN) && (decay_q != decay_tgt_q));
    end

    // Register bus: a simultaneous read and write performs only the write.
    always_comb begin
        en_req_d    = en_req_q;
        delay_tgt_d = delay_tgt_q;
        decay_tgt_d = decay_tgt_q;
        ack_d       = wr_en | rd_en;
        rdata_d     = '0;
        if (wr_en) begin
            case (addr)
                2'd0:    en_req_d    = wdata[0];
                2'd1:    delay_tgt_d = (wdata > DELAY_LIMIT) ? DELAY_LIMIT : wdata;
                2'd2:    decay_tgt_d = (wdata > DECAY_LIMIT) ? DECAY_LIMIT : wdata;
                default: ;
            endcase
        end else if (rd_en) begin
            case (addr)
                2'd0:    rdata_d = {15'd0, en_req_q};
                2'd1:    rdata_d = delay_tgt_q;
                2'd2:    rdata_d = decay_tgt_q;
                default: rdata_d = {13'd0, state_q, busy};
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        enable_d    = enable_q;
        delay_d     = delay_q;
        decay_d     = decay_q;
        flush_cnt_d = flush_cnt_q;
        up_diff     = decay_tgt_q - decay_q;
        dn_diff     = decay_q - decay_tgt_q;
        case (state_q)
            ST_OFF: begin
                enable_d = 1'b0;
                decay_d  = '0;
                if (en_req_q) begin
                    state_d  = ST_RUN;
                    enable_d = 1'b1;
                    delay_d  = delay_tgt_q;
                end
            end
            ST_RUN: begin
                if (!en_req_q || (delay_tgt_q != delay_q)) begin
                    state_d = ST_RAMP_DOWN;
                end else if (tick_in) begin
                    if (decay_q < decay_tgt_q)
                        decay_d = decay_q + ((up_diff > STEP) ? STEP : up_diff);
                    else
                        decay_d = decay_q - ((dn_diff > STEP) ? STEP : dn_diff);
                end
            end
            ST_RAMP_DOWN: begin
                if (decay_q == '0) begin
                    state_d     = ST_FLUSH;
                    enable_d    = 1'b0;
                    flush_cnt_d = FLUSH_INIT;
                end else if (tick_in) begin
                    decay_d = decay_q - ((decay_q > STEP) ? STEP : decay_q);
                end
            end
            ST_FLUSH: begin
                // Leaving on the edge the count hits 0 keeps enable low for exactly FLUSH_CYCLES clocks.
                flush_cnt_d = flush_cnt_q - 16'd1;
                if (flush_cnt_q <= 16'd1) begin
                    flush_cnt_d = '0;
                    if (en_req_q) begin
                        state_d  = ST_RUN;
                        enable_d = 1'b1;
                        delay_d  = delay_tgt_q;
                    end else begin
                        state_d = ST_OFF;
                    end
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= ST_OFF;
            en_req_q    <= 1'b0;
            delay_tgt_q <= '0;
            decay_tgt_q <= '0;
            enable_q    <= 1'b0;
            delay_q     <= '0;
            decay_q     <= '0;
            flush_cnt_q <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            en_req_q    <= en_req_d;
            delay_tgt_q <= delay_tgt_d;
            decay_tgt_q <= decay_tgt_d;
            enable_q    <= enable_d;
            delay_q     <= delay_d;
            decay_q     <= decay_d;
            flush_cnt_q <= flush_cnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    assign rdata      = rdata_q;
    assign ack        = ack_q;
    assign enable_out = enable_q;
    assign delay_out  = delay_q;
    assign decay_out  = decay_q;
    assign busy_out   = busy;

endmodule

// File: tb/tb_echo_ctrl.sv
// Bench for echo_ctrl: directed scenarios plus random bus/tick traffic, all
// outputs compared every cycle against a behavioural sequencing model.
module tb_echo_ctrl;

    localparam int unsigned DML   = 48000;
    localparam int unsigned DSTEP = 64;
    localparam int unsigned FLUSH = 4;

    localparam int P_OFF = 0, P_RUN = 1, P_RAMP = 2, P_FLUSH = 3;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [1:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic        tick_in = 1'b0;
    logic [15:0] rdata;
    logic        ack;
    logic        enable_out;
    logic [15:0] delay_out;
    logic [15:0] decay_out;
    logic        busy_out;

    int n_checks = 0;
    int n_fails  = 0;

    // behavioural model state
    int          m_phase;
    bit          m_en_req;
    int unsigned m_delay_tgt, m_decay_tgt;
    bit          m_enable;
    int unsigned m_delay, m_decay, m_flush_left;
    bit          m_ack;
    int unsigned m_rdata;

    echo_ctrl #(
        .DELAY_MAX_LENGTH(DML),
        .DECAY_STEP(DSTEP),
        .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk(clk),
        .srst(srst),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .ack(ack),
        .tick_in(tick_in),
        .enable_out(enable_out),
        .delay_out(delay_out),
        .decay_out(decay_out),
        .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    function automatic bit m_busy();
        return (m_phase == P_RAMP) || (m_phase == P_FLUSH) ||
               ((m_phase == P_RUN) && (m_decay != m_decay_tgt));
    endfunction

    task automatic model_reset();
        m_phase = P_OFF; m_en_req = 0; m_delay_tgt = 0; m_decay_tgt = 0;
        m_enable = 0; m_delay = 0; m_decay = 0; m_flush_left = 0;
        m_ack = 0; m_rdata = 0;
    endtask

    // One clock edge of the model, using the inputs present at the edge.
    task automatic model_edge();
        bit          n_en;
        int unsigned n_dly, n_dcy, v;
        if (srst) begin
            model_reset();
            return;
        end
        n_en = m_en_req; n_dly = m_delay_tgt; n_dcy = m_decay_tgt;
        m_ack = wr_en || rd_en;
        m_rdata = 0;
        v = int'(wdata);
        if (wr_en) begin
            if (addr == 2'd0) n_en = wdata[0];
            if (addr == 2'd1) n_dly = min_u(v, DML - 1);
            if (addr == 2'd2) n_dcy = min_u(v, 32'h7FFF);
        end else if (rd_en) begin
            case (addr)
                2'd0: m_rdata = m_en_req;
                2'd1: m_rdata = m_delay_tgt;
                2'd2: m_rdata = m_decay_tgt;
                default: m_rdata = m_phase * 2 + (m_busy() ? 1 : 0);
            endcase
        end
        case (m_phase)
            P_OFF: begin
                m_decay = 0;
                if (m_en_req) begin
                    m_phase = P_RUN; m_enable = 1; m_delay = m_delay_tgt;
                end
            end
            P_RUN: begin
                if (!m_en_req || m_delay_tgt != m_delay) m_phase = P_RAMP;
                else if (tick_in) begin
                    if (m_decay < m_decay_tgt) m_decay += min_u(DSTEP, m_decay_tgt - m_decay);
                    else m_decay -= min_u(DSTEP, m_decay - m_decay_tgt);
                end
            end
            P_RAMP: begin
                if (m_decay == 0) begin
                    m_phase = P_FLUSH; m_enable = 0; m_flush_left = FLUSH;
                end else if (tick_in) m_decay -= min_u(DSTEP, m_decay);
            end
            default: begin
                m_flush_left--;
                if (m_flush_left == 0) begin
                    if (m_en_req) begin
                        m_phase = P_RUN; m_enable = 1; m_delay = m_delay_tgt;
                    end else m_phase = P_OFF;
                end
            end
        endcase
        m_en_req = n_en; m_delay_tgt = n_dly; m_decay_tgt = n_dcy;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("ack", ack, m_ack);
        check("rdata", rdata, m_rdata);
        check("enable_out", enable_out, m_enable);
        check("delay_out", delay_out, m_delay);
        check("decay_out", decay_out, m_decay);
        check("busy_out", busy_out, m_busy());
        wr_en = 0; rd_en = 0; tick_in = 0; srst = 0;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
        wr_en = 1; addr = a; wdata = d;
        step();
    endtask

    task automatic bus_rd(input logic [1:0] a);
        rd_en = 1; addr = a;
        step();
    endtask

    task automatic idle(input bit t);
        tick_in = t;
        step();
    endtask

    initial begin
        int  cnt;
        bit  done;
        int unsigned r;
        model_reset();

        // reset and bus
        srst = 1; step();
        srst = 1; step();
        check("rst_enable", enable_out, 0);
        check("rst_delay", delay_out, 0);
        check("rst_decay", decay_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_ack", ack, 0);
        bus_wr(2'd1, 16'd1000);
        check("wr_ack", ack, 1);
        bus_rd(2'd1);
        check("rd_ack", ack, 1);
        check("rd_delay", rdata, 1000);
        idle(0);
        check("ack_drop", ack, 0);
        bus_wr(2'd2, 16'h4000);
        bus_rd(2'd2);
        check("rd_decay", rdata, 16'h4000);
        check("off_enable", enable_out, 0);
        check("off_decay", decay_out, 0);

        // clamping and status
        bus_wr(2'd1, 16'hFFFF);
        bus_rd(2'd1);
        check("delay_clamp", rdata, DML - 1);
        bus_wr(2'd2, 16'h9000);
        bus_rd(2'd2);
        check("decay_clamp", rdata, 16'h7FFF);
        bus_wr(2'd3, 16'hFFFF);
        check("status_wr_ack", ack, 1);
        bus_rd(2'd3);
        check("status_off", rdata, 0);
        wr_en = 1; rd_en = 1; addr = 2'd2; wdata = 16'd100;
        step();
        check("both_ack", ack, 1);
        check("both_rdata", rdata, 0);
        idle(0);
        check("both_single_ack", ack, 0);

        // enable ramp
        bus_wr(2'd2, 16'd256);
        bus_wr(2'd0, 16'd1);
        check("en_not_yet", enable_out, 0);
        idle(0);
        check("en_rise", enable_out, 1);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("ramp_up", decay_out, 64 * (i + 1));
            check("ramp_up_busy", busy_out, (i < 3) ? 1 : 0);
        end

        // delay change sequence
        bus_wr(2'd1, 16'd500);
        idle(0);
        check("rd_busy", busy_out, 1);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("ramp_down", decay_out, 256 - 64 * (i + 1));
        end
        cnt = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            idle(0);
            if (!enable_out) cnt++;
            else if (cnt > 0) done = 1;
        end
        check("flush_done", done, 1);
        check("flush_low_cycles", cnt, FLUSH);
        check("new_delay", delay_out, 500);
        for (int i = 0; i < 4; i++) idle(1);
        check("ramp_back", decay_out, 256);

        // disable during ramp-up
        bus_wr(2'd2, 16'd1024);
        idle(1);
        idle(1);
        check("mid_ramp", decay_out, 384);
        bus_wr(2'd0, 16'd0);
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            idle(1);
            if (!busy_out) done = 1;
        end
        check("off_reached", done, 1);
        check("off_enable2", enable_out, 0);
        check("off_decay2", decay_out, 0);
        bus_rd(2'd3);
        check("status_off2", rdata, 0);

        // reset during flush
        bus_wr(2'd0, 16'd1);
        idle(0);
        check("re_enable", enable_out, 1);
        bus_wr(2'd1, 16'd800);
        idle(0);
        idle(0);
        check("in_flush_enable", enable_out, 0);
        check("in_flush_busy", busy_out, 1);
        srst = 1; step();
        check("srst_enable", enable_out, 0);
        check("srst_delay", delay_out, 0);
        check("srst_decay", decay_out, 0);
        check("srst_busy", busy_out, 0);
        idle(0);
        check("srst_stays_off", enable_out, 0);
        bus_rd(2'd1);
        check("srst_tgt_lost", rdata, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 3) srst = 1;
            r = $urandom_range(0, 99);
            addr = 2'($urandom_range(0, 3));
            wdata = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023));
            if (addr == 2'd0) wdata = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            wr_en = (r < 4) || (r == 12);
            rd_en = (r >= 4 && r <= 12);
            tick_in = ($urandom_range(0, 9) < 3);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
